// File: rtl/sreg_cmd_queue.sv
// sreg_cmd_queue: host command FIFO and one-at-a-time dispatcher in front of sreg_ctrl.
// Define SREG_CMDQ_RSP_EN to build the read-response FIFO; otherwise read results are dropped.
module sreg_cmd_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned BUSY_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [2:0]               host_cmd,
  input  logic [41:0]              host_data,
  input  logic                     flush,
  output logic                     ctrl_cmd_valid,
  output logic [2:0]               ctrl_cmd,
  output logic [41:0]              ctrl_data_in,
  input  logic                     ctrl_cmd_ready,
  input  logic [41:0]              ctrl_data_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_cmd,
  output logic [41:0]              rsp_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned BW_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [BW_W-1:0] BW_LAST  = BW_W'(BUSY_WAIT - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [44:0]       cq_mem_q [DEPTH];
  logic [AW-1:0]     cq_wr_q, cq_wr_d, cq_rd_q, cq_rd_d;
  logic [CW-1:0]     cq_cnt_q, cq_cnt_d;
  logic              avail_q, avail_d;
  logic [BW_W-1:0]   bw_cnt_q, bw_cnt_d;
  logic              ctrl_cmd_valid_q, ctrl_cmd_valid_d;
  logic [2:0]        ctrl_cmd_q, ctrl_cmd_d;
  logic [41:0]       ctrl_data_q, ctrl_data_d;
  logic              busy_q, busy_d;
  logic              push, pop, rsp_push, rsp_slot_ok;
  logic [44:0]       head;

  function automatic logic is_read(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b111);
  endfunction

  assign host_ready = (cq_cnt_q != FULL_CNT);
  assign push       = host_valid && host_ready && !flush;
  assign head       = cq_mem_q[cq_rd_q];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rsp_push    = 1'b0;
    bw_cnt_d    = bw_cnt_q;
    ctrl_cmd_d  = ctrl_cmd_q;
    ctrl_data_d = ctrl_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (avail_q && ctrl_cmd_ready && rsp_slot_ok) begin
          pop         = 1'b1;
          ctrl_cmd_d  = head[44:42];
          ctrl_data_d = head[41:0];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bw_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!ctrl_cmd_ready) begin
          state_d = S_WAIT_DONE;
        end else if (bw_cnt_q == BW_LAST) begin
          state_d = S_DONE;
        end else begin
          bw_cnt_d = bw_cnt_q + BW_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (ctrl_cmd_ready) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_push = is_read(ctrl_cmd_q);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dispatch eligibility is a registered view of occupancy: it lags pushes by one
  // cycle and is cleared on pop/flush, so it can only ever under-report entries.
  always_comb begin
    cq_wr_d  = cq_wr_q + AW'(push);
    cq_rd_d  = cq_rd_q + AW'(pop);
    cq_cnt_d = cq_cnt_q + CW'(push) - CW'(pop);
    avail_d  = (cq_cnt_q != '0) && !pop;
    if (flush) begin
      cq_rd_d  = cq_wr_q;
      cq_cnt_d = '0;
      avail_d  = 1'b0;
    end
    busy_d           = (state_d != S_IDLE) || (cq_cnt_d != '0);
    ctrl_cmd_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (push) cq_mem_q[cq_wr_q] <= {host_cmd, host_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cq_wr_q          <= '0;
      cq_rd_q          <= '0;
      cq_cnt_q         <= '0;
      avail_q          <= 1'b0;
      bw_cnt_q         <= '0;
      ctrl_cmd_valid_q <= 1'b0;
      ctrl_cmd_q       <= '0;
      ctrl_data_q      <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cq_wr_q          <= cq_wr_d;
      cq_rd_q          <= cq_rd_d;
      cq_cnt_q         <= cq_cnt_d;
      avail_q          <= avail_d;
      bw_cnt_q         <= bw_cnt_d;
      ctrl_cmd_valid_q <= ctrl_cmd_valid_d;
      ctrl_cmd_q       <= ctrl_cmd_d;
      ctrl_data_q      <= ctrl_data_d;
      busy_q           <= busy_d;
    end
  end

  assign ctrl_cmd_valid = ctrl_cmd_valid_q;
  assign ctrl_cmd       = ctrl_cmd_q;
  assign ctrl_data_in   = ctrl_data_q;
  assign level          = cq_cnt_q;
  assign busy           = busy_q;

`ifdef SREG_CMDQ_RSP_EN
  localparam int unsigned RAW = $clog2(RSP_DEPTH);
  localparam int unsigned RCW = RAW + 1;
  localparam logic [RCW-1:0] RSP_FULL = RCW'(RSP_DEPTH);

  logic [44:0]    rq_mem_q [RSP_DEPTH];
  logic [RAW-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic [RCW-1:0] rq_cnt_q, rq_cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [44:0]    rsp_head_q, rsp_head_d;
  logic           rsp_pop;
  logic [44:0]    rsp_wdata;

  assign rsp_pop   = rsp_valid_q && rsp_ready;
  assign rsp_wdata = {ctrl_cmd_q, ctrl_data_out};
  // A read's slot is claimed in DONE before the FSM can return to IDLE, so the
  // occupancy seen here already includes every earlier in-flight read.
  assign rsp_slot_ok = !is_read(head[44:42]) || (rq_cnt_q != RSP_FULL);

  always_comb begin
    rq_wr_d     = rq_wr_q + RAW'(rsp_push);
    rq_rd_d     = rq_rd_q + RAW'(rsp_pop);
    rq_cnt_d    = rq_cnt_q + RCW'(rsp_push) - RCW'(rsp_pop);
    rsp_valid_d = (rq_cnt_d != '0);
    rsp_head_d  = '0;
    if (rq_cnt_d != '0) begin
      rsp_head_d = (rsp_push && (rq_wr_q == rq_rd_d)) ? rsp_wdata : rq_mem_q[rq_rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) rq_mem_q[rq_wr_q] <= rsp_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wr_q     <= '0;
      rq_rd_q     <= '0;
      rq_cnt_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_head_q  <= '0;
    end else begin
      rq_wr_q     <= rq_wr_d;
      rq_rd_q     <= rq_rd_d;
      rq_cnt_q    <= rq_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_head_q  <= rsp_head_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_cmd   = rsp_head_q[44:42];
  assign rsp_data  = rsp_head_q[41:0];
`else
  logic unused_rsp;
  assign unused_rsp  = ^{rsp_ready, ctrl_data_out, rsp_push};
  assign rsp_slot_ok = 1'b1;
  assign rsp_valid   = 1'b0;
  assign rsp_cmd     = '0;
  assign rsp_data    = '0;
`endif

endmodule
